// File: rtl/door_access_ctrl_pkg.sv
// door_pkg: shared types and helpers for the door strike controller.
//   state_t   - controller state encoding
//   KEY_CLEAR - keypad code that discards a partial PIN
//   is_digit  - true for keypad codes 0-9
//   max3      - largest of three cycle counts, used to size the shared timer
package door_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/door_access_ctrl_if.sv
// door_access_ctrl_if: keypad, booking and strike signals of the door controller.
//   key_valid/key_code        keypad strobe and code (0-9 digit, A = clear)
//   room_booked/booked_pin    booking level and its BCD PIN (first digit in MS nibble)
//   unlock_req/lock_req       pushbutton unlock and forced relock strobes
//   door_unlock/lockout/pin_fail/entry_busy/fail_count  controller status
// master = keypad/booking side, slave = controller.
interface door_access_ctrl_if #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned MAX_FAIL   = 3
);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  logic                      key_valid;
  logic [3:0]                key_code;
  logic                      room_booked;
  logic [4*PIN_DIGITS-1:0]   booked_pin;
  logic                      unlock_req;
  logic                      lock_req;
  logic                      door_unlock;
  logic                      lockout;
  logic                      pin_fail;
  logic                      entry_busy;
  logic [FAIL_W-1:0]         fail_count;

  modport master (
    output key_valid, key_code, room_booked, booked_pin, unlock_req, lock_req,
    input  door_unlock, lockout, pin_fail, entry_busy, fail_count
  );

  modport slave (
    input  key_valid, key_code, room_booked, booked_pin, unlock_req, lock_req,
    output door_unlock, lockout, pin_fail, entry_busy, fail_count
  );

endinterface

// File: rtl/door_access_ctrl_timer.sv
// door_timer: loadable up-counter with terminal flag.
//   clk, reset  clock and synchronous active-high reset
//   load        restart counting from zero on the next edge
//   term        terminal count (cycles - 1) of the current interval
//   done        high while the count equals term
module door_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] term,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Counter saturates at all-ones so an idle controller never wraps into a false terminal hit.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/door_access_ctrl.sv
// door_access_ctrl: sequencing controller for the room door strike.
//   clk, reset  clock and synchronous active-high reset
//   bus         door_access_ctrl_if.slave: keypad, booking, pushbutton inputs and
//               strike/status outputs (all outputs registered)
// Free room: pushbutton unlocks. Booked room: a PIN_DIGITS-digit PIN is collected,
// compared, and either unlocks or counts a failure; MAX_FAIL failures lock out.
module door_access_ctrl
  import door_pkg::*;
#(
  parameter int unsigned PIN_DIGITS   = 4,
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned UNLOCK_CYC   = 250_000_000,
  parameter int unsigned LOCKOUT_CYC  = 1_500_000_000,
  parameter int unsigned ENTRY_TO_CYC = 500_000_000
) (
  input  logic               clk,
  input  logic               reset,
  door_access_ctrl_if.slave  bus
);

  localparam int unsigned PIN_W   = 4 * PIN_DIGITS;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int unsigned CNT_W   = $clog2(PIN_DIGITS + 1);
  localparam int unsigned MAX_CYC = max3(UNLOCK_CYC, LOCKOUT_CYC, ENTRY_TO_CYC);
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  state_t             state, next_state;
  logic [PIN_W-1:0]   pin_buf;
  logic [CNT_W-1:0]   digit_cnt;
  logic [FAIL_W-1:0]  fail_count_q, fail_count_d, fail_next;
  logic               door_unlock_q, lockout_q, pin_fail_q, entry_busy_q;
  logic               door_unlock_d, lockout_d, pin_fail_d, entry_busy_d;
  logic               digit_take, clear_take, pin_match;
  logic               timer_restart, timer_load, timer_done;
  logic [TMR_W-1:0]   timer_term;

  assign digit_take = bus.key_valid && is_digit(bus.key_code);
  assign clear_take = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign pin_match  = (pin_buf == bus.booked_pin);
  assign fail_next  = (fail_count_q == FAIL_W'(MAX_FAIL)) ? fail_count_q
                                                          : fail_count_q + FAIL_W'(1);

  // One timer serves every timed state; it restarts on each state entry and on
  // in-state restarts (new digit, pushbutton re-press while open).
  assign timer_load = (next_state != state) || timer_restart;

  always_comb begin
    timer_term = '0;
    case (state)
      ST_ENTRY:    timer_term = TMR_W'(ENTRY_TO_CYC - 1);
      ST_UNLOCKED: timer_term = TMR_W'(UNLOCK_CYC - 1);
      ST_LOCKOUT:  timer_term = TMR_W'(LOCKOUT_CYC - 1);
      default:     timer_term = '0;
    endcase
  end

  door_timer #(.WIDTH(TMR_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .term  (timer_term),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. In ENTRY a key beats a simultaneous timeout; in UNLOCKED a
  // relock beats everything, so relock and expiry together leave exactly once.
  always_comb begin
    next_state    = state;
    timer_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.room_booked && bus.unlock_req) begin
          next_state = ST_UNLOCKED;
        end else if (bus.room_booked && digit_take) begin
          next_state = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (!bus.room_booked || clear_take) begin
          next_state = ST_IDLE;
        end else if (digit_take) begin
          timer_restart = 1'b1;
          if (digit_cnt == CNT_W'(PIN_DIGITS - 1)) begin
            next_state = ST_CHECK;
          end
        end else if (timer_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (pin_match) begin
          next_state = ST_UNLOCKED;
        end else if (fail_next == FAIL_W'(MAX_FAIL)) begin
          next_state = ST_LOCKOUT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_UNLOCKED: begin
        if (bus.lock_req) begin
          next_state = ST_IDLE;
        end else if (bus.unlock_req && !bus.room_booked) begin
          timer_restart = 1'b1;
        end else if (timer_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (timer_done) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: status flags follow the state being entered so the registered
  // outputs line up with the state register.
  always_comb begin
    door_unlock_d = (next_state == ST_UNLOCKED);
    lockout_d     = (next_state == ST_LOCKOUT);
    entry_busy_d  = (next_state == ST_ENTRY);
    pin_fail_d    = (state == ST_CHECK) && !pin_match;
    fail_count_d  = fail_count_q;
    if (state == ST_CHECK) begin
      fail_count_d = pin_match ? '0 : fail_next;
    end else if ((state == ST_LOCKOUT) && timer_done) begin
      fail_count_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      door_unlock_q <= 1'b0;
      lockout_q     <= 1'b0;
      pin_fail_q    <= 1'b0;
      entry_busy_q  <= 1'b0;
      fail_count_q  <= '0;
    end else begin
      door_unlock_q <= door_unlock_d;
      lockout_q     <= lockout_d;
      pin_fail_q    <= pin_fail_d;
      entry_busy_q  <= entry_busy_d;
      fail_count_q  <= fail_count_d;
    end
  end

  // Digit buffer: first digit loads, later digits shift in from the right; it is
  // held only while entry continues and cleared on any other path (incl. after CHECK).
  always_ff @(posedge clk) begin
    if (reset) begin
      pin_buf   <= '0;
      digit_cnt <= '0;
    end else if ((state == ST_IDLE) && (next_state == ST_ENTRY)) begin
      pin_buf   <= PIN_W'(bus.key_code);
      digit_cnt <= CNT_W'(1);
    end else if ((state == ST_ENTRY) && (next_state != ST_IDLE) && digit_take) begin
      pin_buf   <= (pin_buf << 4) | PIN_W'(bus.key_code);
      digit_cnt <= digit_cnt + CNT_W'(1);
    end else if (next_state != ST_ENTRY) begin
      pin_buf   <= '0;
      digit_cnt <= '0;
    end
  end

  assign bus.door_unlock = door_unlock_q;
  assign bus.lockout     = lockout_q;
  assign bus.pin_fail    = pin_fail_q;
  assign bus.entry_busy  = entry_busy_q;
  assign bus.fail_count  = fail_count_q;

endmodule
